mmio_hub: RTL and testbench

- Second-generation memory-mapped I/O hub between the core's data path and the UART and performance counters.
- Adds registered read data, parametrised RX/TX FIFOs so the core no longer spins per byte, internal cycle/instruction counters, and a sticky TX-drop flag.
- Decodes addresses with addr_in[31]==1 as the MMIO space; offset is addr_in[7:0].

---
 rtl/mmio_pkg.sv | 15 +
 rtl/mmio_sync_fifo.sv | 56 +++++
 rtl/mmio_hub.sv | 122 ++++++++++++
 tb/tb_mmio_hub.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared offsets and status-bit positions for the MMIO hub.
// Offsets are compared against addr_in[7:0] inside the MMIO window.
package mmio_pkg;
    localparam logic [7:0] MMIO_STATUS   = 8'h00;
    localparam logic [7:0] MMIO_RX_DATA  = 8'h04;
    localparam logic [7:0] MMIO_TX_DATA  = 8'h08;
    localparam logic [7:0] MMIO_CLR_DROP = 8'h0C;
    localparam logic [7:0] MMIO_CYCLE    = 8'h10;
    localparam logic [7:0] MMIO_INST     = 8'h14;
    localparam logic [7:0] MMIO_CNT_RST  = 8'h18;

    localparam int STAT_TX_NOT_FULL  = 0;
    localparam int STAT_RX_NOT_EMPTY = 1;
    localparam int STAT_TX_DROP      = 2;
endpackage

// File: rtl/mmio_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output and guarded push/pop.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module mmio_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_FULL);
    assign count     = r_count;
    assign dout      = r_mem[r_rptr];
    // Pop is qualified by pre-edge occupancy, so a freshly pushed entry cannot leave in the same cycle.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= din;
    end
endmodule

// File: rtl/mmio_hub.sv
// MMIO hub: UART RX/TX FIFOs, cycle/instruction counters and a sticky TX-drop flag
// behind a registered-read register window at addr_in[31]==1.
module mmio_hub
    import mmio_pkg::*;
#(
    parameter int AWIDTH    = 32,
    parameter int DWIDTH    = 32,
    parameter int TX_DEPTH  = 8,
    parameter int RX_DEPTH  = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AWIDTH-1:0] addr_in,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              re_in,
    input  logic              we_in,
    input  logic              inst_commit_in,
    output logic [DWIDTH-1:0] data_reg_out,
    input  logic [7:0]        uart_rx_data_in,
    input  logic              uart_rx_valid_in,
    output logic              uart_rx_ready_out,
    output logic [7:0]        uart_tx_data_out,
    output logic              uart_tx_valid_out,
    input  logic              uart_tx_ready_in
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic                      w_mmio;
    logic [7:0]                w_off;
    logic                      w_rd_rx;
    logic                      w_wr_tx;
    logic                      w_clr_drop;
    logic                      w_cnt_clr;
    logic                      w_tx_full, w_tx_empty, w_tx_pop;
    logic                      w_rx_full, w_rx_empty, w_rx_push;
    logic [7:0]                w_rx_dout;
    logic [$clog2(TX_DEPTH):0] w_tx_count;
    logic [$clog2(RX_DEPTH):0] w_rx_count;
    logic [DWIDTH-1:0]         w_rd_data;
    logic                      w_unused_bits;
    logic                      r_tx_drop;
    logic [CNT_WIDTH-1:0]      r_cycle;
    logic [CNT_WIDTH-1:0]      r_inst;
    logic [DWIDTH-1:0]         r_data;

    assign w_mmio        = addr_in[AWIDTH-1];
    assign w_off         = addr_in[7:0];
    assign w_rd_rx       = re_in && w_mmio && (w_off == MMIO_RX_DATA);
    assign w_wr_tx       = we_in && w_mmio && (w_off == MMIO_TX_DATA);
    assign w_clr_drop    = we_in && w_mmio && (w_off == MMIO_CLR_DROP);
    assign w_cnt_clr     = we_in && w_mmio && (w_off == MMIO_CNT_RST);
    assign w_tx_pop      = !w_tx_empty && uart_tx_ready_in;
    assign w_rx_push     = uart_rx_valid_in && !w_rx_full;
    assign w_unused_bits = ^{addr_in[AWIDTH-2:8], data_in[DWIDTH-1:8], w_tx_count, w_rx_count};

    mmio_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_wr_tx),
        .pop   (w_tx_pop),
        .din   (data_in[7:0]),
        .dout  (uart_tx_data_out),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count)
    );

    mmio_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_rx_push),
        .pop   (w_rd_rx),
        .din   (uart_rx_data_in),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_rx_count)
    );

    assign uart_tx_valid_out = !w_tx_empty;
    assign uart_rx_ready_out = !w_rx_full;
    assign data_reg_out      = r_data;

    always_comb begin
        w_rd_data = '0;
        if (w_mmio) begin
            case (w_off)
                MMIO_STATUS: begin
                    w_rd_data[STAT_TX_NOT_FULL]  = !w_tx_full;
                    w_rd_data[STAT_RX_NOT_EMPTY] = !w_rx_empty;
                    w_rd_data[STAT_TX_DROP]      = r_tx_drop;
                end
                MMIO_RX_DATA: w_rd_data = w_rx_empty ? '0 : DWIDTH'(w_rx_dout);
                MMIO_CYCLE:   w_rd_data = DWIDTH'(r_cycle);
                MMIO_INST:    w_rd_data = DWIDTH'(r_inst);
                default:      w_rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_tx_drop <= 1'b0;
            r_cycle   <= '0;
            r_inst    <= '0;
        end else begin
            if (re_in) r_data <= w_rd_data;
            // A write while full is dropped unless the transmitter frees a slot this same edge.
            if (w_wr_tx && w_tx_full && !w_tx_pop) r_tx_drop <= 1'b1;
            else if (w_clr_drop)                   r_tx_drop <= 1'b0;
            if (w_cnt_clr) begin
                r_cycle <= '0;
                r_inst  <= '0;
            end else begin
                r_cycle <= r_cycle + CNT_ONE;
                if (inst_commit_in) r_inst <= r_inst + CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_mmio_hub.sv
// Directed self-checking bench for mmio_hub: reset, TX path, overflow/drop, RX path,
// counters and reset during a TX drain.
module tb_mmio_hub;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] din;
    logic        re, we, commit;
    logic [31:0] dout;
    logic [7:0]  rxd;
    logic        rxv, rxr;
    logic [7:0]  txd;
    logic        txv, txr;
    int          n_checks = 0;
    int          n_pass   = 0;

    mmio_hub dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .addr_in           (addr),
        .data_in           (din),
        .re_in             (re),
        .we_in             (we),
        .inst_commit_in    (commit),
        .data_reg_out      (dout),
        .uart_rx_data_in   (rxd),
        .uart_rx_valid_in  (rxv),
        .uart_rx_ready_out (rxr),
        .uart_tx_data_out  (txd),
        .uart_tx_valid_out (txv),
        .uart_tx_ready_in  (txr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] off);
        addr = {24'h800000, off};
        re   = 1'b1;
        tick();
        re   = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [7:0] d);
        addr = {24'h800000, off};
        din  = {24'h0, d};
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; addr = '0; din = '0; re = 0; we = 0; commit = 0;
        rxd = '0; rxv = 0; txr = 0;
        #12;
        n_checks++; if (dout !== 32'h0) $display("FAIL reset_dout got %h want 0", dout); else n_pass++;
        n_checks++; if (txv !== 1'b0) $display("FAIL reset_txv got %b want 0", txv); else n_pass++;
        n_checks++; if (rxr !== 1'b1) $display("FAIL reset_rxr got %b want 1", rxr); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        rd(8'h00);
        n_checks++; if (dout !== 32'h1) $display("FAIL reset_status got %h want 1", dout); else n_pass++;
        tick();
        n_checks++; if (dout !== 32'h1) $display("FAIL read_hold got %h want 1", dout); else n_pass++;
        addr = 32'h0000_0000; re = 1'b1; tick(); re = 1'b0;
        n_checks++; if (dout !== 32'h0) $display("FAIL outside_space got %h want 0", dout); else n_pass++;
        rd(8'h20);
        n_checks++; if (dout !== 32'h0) $display("FAIL unmapped got %h want 0", dout); else n_pass++;
    endtask

    task automatic test_tx;
        txr = 1'b0;
        wr(8'h08, 8'h41);
        wr(8'h08, 8'h42);
        n_checks++; if (txv !== 1'b1 || txd !== 8'h41) $display("FAIL tx_head got v=%b d=%h want v=1 d=41", txv, txd); else n_pass++;
        txr = 1'b1;
        tick();
        n_checks++; if (txv !== 1'b1 || txd !== 8'h42) $display("FAIL tx_second got v=%b d=%h want v=1 d=42", txv, txd); else n_pass++;
        tick();
        n_checks++; if (txv !== 1'b0) $display("FAIL tx_drained got %b want 0", txv); else n_pass++;
        txr = 1'b0;
    endtask

    task automatic test_overflow;
        txr = 1'b0;
        for (int i = 0; i < 9; i++) wr(8'h08, 8'(8'h10 + i));
        rd(8'h00);
        n_checks++; if (dout !== 32'h4) $display("FAIL ovf_status got %h want 4", dout); else n_pass++;
        wr(8'h0C, 8'h00);
        rd(8'h00);
        n_checks++; if (dout !== 32'h0) $display("FAIL clr_drop got %h want 0", dout); else n_pass++;
        // Write into a full FIFO while the transmitter pops: must be accepted, no drop.
        txr  = 1'b1;
        wr(8'h08, 8'h99);
        txr  = 1'b0;
        rd(8'h00);
        n_checks++; if (dout !== 32'h0) $display("FAIL full_push_pop got %h want 0", dout); else n_pass++;
        txr = 1'b1;
        for (int i = 1; i < 9; i++) begin
            n_checks++;
            if (txv !== 1'b1 || txd !== ((i == 8) ? 8'h99 : 8'(8'h10 + i)))
                $display("FAIL drain_%0d got v=%b d=%h want %h", i, txv, txd, (i == 8) ? 8'h99 : 8'(8'h10 + i));
            else n_pass++;
            tick();
        end
        n_checks++; if (txv !== 1'b0) $display("FAIL drain_empty got %b want 0", txv); else n_pass++;
        txr = 1'b0;
    endtask

    task automatic test_rx;
        rxv = 1'b1; rxd = 8'h55; tick();
        rxd = 8'hAA; tick();
        rxv = 1'b0;
        rd(8'h00);
        n_checks++; if (dout !== 32'h3) $display("FAIL rx_status got %h want 3", dout); else n_pass++;
        rd(8'h04);
        n_checks++; if (dout !== 32'h55) $display("FAIL rx_pop1 got %h want 55", dout); else n_pass++;
        rd(8'h04);
        n_checks++; if (dout !== 32'hAA) $display("FAIL rx_pop2 got %h want aa", dout); else n_pass++;
        rd(8'h00);
        n_checks++; if (dout !== 32'h1) $display("FAIL rx_status_empty got %h want 1", dout); else n_pass++;
        rd(8'h04);
        n_checks++; if (dout !== 32'h0) $display("FAIL rx_pop_empty got %h want 0", dout); else n_pass++;
        rxv = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rxd = 8'(8'h60 + i);
            tick();
        end
        n_checks++; if (rxr !== 1'b0) $display("FAIL rx_full_ready got %b want 0", rxr); else n_pass++;
        rxd = 8'hEE; tick();
        rxv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd(8'h04);
            n_checks++;
            if (dout !== 32'(8'h60 + i)) $display("FAIL rx_fill_%0d got %h want %h", i, dout, 8'(8'h60 + i));
            else n_pass++;
        end
        rd(8'h04);
        n_checks++; if (dout !== 32'h0) $display("FAIL rx_no_overrun got %h want 0", dout); else n_pass++;
    endtask

    task automatic test_counters;
        int exp_inst;
        exp_inst = 0;
        wr(8'h18, 8'h00);
        for (int i = 0; i < 100; i++) begin
            commit = (i % 2 == 1);
            if (commit) exp_inst++;
            tick();
        end
        commit = 1'b0;
        rd(8'h10);
        n_checks++; if (dout !== 32'd100) $display("FAIL cycle_cnt got %0d want 100", dout); else n_pass++;
        rd(8'h14);
        n_checks++; if (dout !== 32'(exp_inst)) $display("FAIL inst_cnt got %0d want %0d", dout, exp_inst); else n_pass++;
        commit = 1'b1;
        wr(8'h18, 8'h00);
        commit = 1'b0;
        rd(8'h10);
        n_checks++; if (dout !== 32'd0) $display("FAIL cycle_clr got %0d want 0", dout); else n_pass++;
        rd(8'h10);
        n_checks++; if (dout !== 32'd1) $display("FAIL cycle_after_clr got %0d want 1", dout); else n_pass++;
        rd(8'h14);
        n_checks++; if (dout !== 32'd0) $display("FAIL inst_clr got %0d want 0", dout); else n_pass++;
    endtask

    task automatic test_reset_mid_drain;
        txr = 1'b0;
        wr(8'h08, 8'hA1);
        wr(8'h08, 8'hA2);
        wr(8'h08, 8'hA3);
        rd(8'h10);
        txr = 1'b1;
        tick();
        n_checks++; if (txv !== 1'b1 || txd !== 8'hA2) $display("FAIL mid_drain got v=%b d=%h want v=1 d=a2", txv, txd); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (txv !== 1'b0) $display("FAIL async_rst_txv got %b want 0", txv); else n_pass++;
        n_checks++; if (dout !== 32'h0) $display("FAIL async_rst_dout got %h want 0", dout); else n_pass++;
        txr = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        rd(8'h10);
        n_checks++; if (dout !== 32'h0) $display("FAIL rst_cycle got %0d want 0", dout); else n_pass++;
        rd(8'h14);
        n_checks++; if (dout !== 32'h0) $display("FAIL rst_inst got %0d want 0", dout); else n_pass++;
        rd(8'h00);
        n_checks++; if (dout !== 32'h1) $display("FAIL rst_status got %h want 1", dout); else n_pass++;
        n_checks++; if (txv !== 1'b0) $display("FAIL rst_tx_empty got %b want 0", txv); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_tx();
        test_overflow();
        test_rx();
        test_counters();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
